// File: rtl/multicycle_control.sv
// Multicycle MIPS-style main controller.
// Moore FSM: every control output is decoded from the registered state only.
// The only registered side output is `illegal`, a one-cycle pulse seen in
// the FETCH that follows a DECODE of an undefined opcode.
module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       PCWriteCondNE,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    RTEXEC = 4'd6,
    RTWB   = 4'd7,
    BEQ    = 4'd8,
    JUMP   = 4'd9,
    BNE    = 4'd10,
    ADDIEX = 4'd11,
    ANDIEX = 4'd12,
    ITWB   = 4'd13
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // The state register is kept as a plain 4-bit vector so the two unused
  // codes (14, 15) are representable and recover through the default arm.
  logic [3:0] state_q, state_d;
  logic       illegal_q, illegal_d;
  logic [5:0] opcode_q, opcode_d;

  // State, illegal pulse and opcode hold register; reset is asynchronous.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= FETCH;
      illegal_q <= 1'b0;
      opcode_q  <= 6'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      opcode_q  <= opcode_d;
    end
  end

  // Next-state logic; opcode is captured on the DECODE cycle and the held
  // copy steers MEMADR so later opcode changes cannot redirect the path.
  // NOTE: every variable gets a default before the case so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = FETCH;
    illegal_d = 1'b0;
    opcode_d  = opcode_q;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        opcode_d = opcode;
        case (opcode)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = RTEXEC;
          OP_BEQ:       state_d = BEQ;
          OP_BNE:       state_d = BNE;
          OP_J:         state_d = JUMP;
          OP_ADDI:      state_d = ADDIEX;
          OP_ANDI:      state_d = ANDIEX;
          default: begin
            state_d   = FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      MEMADR: state_d = (opcode_q == OP_SW) ? MEMWR : MEMRD;
      MEMRD:  state_d = MEMWB;
      RTEXEC: state_d = RTWB;
      ADDIEX: state_d = ITWB;
      ANDIEX: state_d = ITWB;
      default: state_d = FETCH;  // MEMWB, MEMWR, RTWB, BEQ, BNE, JUMP, ITWB, 14, 15
    endcase
  end

  // Moore output decode: everything defaults to 0, each state raises its own.
  always_comb begin
    PCWrite       = 1'b0;
    PCWriteCond   = 1'b0;
    PCWriteCondNE = 1'b0;
    IorD          = 1'b0;
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    IRWrite       = 1'b0;
    MemtoReg      = 1'b0;
    RegDst        = 1'b0;
    RegWrite      = 1'b0;
    ALUSrcA       = 1'b0;
    ALUSrcB       = 2'b00;
    ALUOp         = 2'b00;
    PCSource      = 2'b00;
    case (state_q)
      FETCH: begin
        MemRead = 1'b1;
        IRWrite = 1'b1;
        PCWrite = 1'b1;
        ALUSrcB = 2'b01;
      end
      DECODE: ALUSrcB = 2'b11;
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      RTEXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      RTWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      BEQ: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
      BNE: begin
        ALUSrcA       = 1'b1;
        ALUOp         = 2'b01;
        PCWriteCondNE = 1'b1;
        PCSource      = 2'b01;
      end
      JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      ANDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOp   = 2'b11;
      end
      ITWB: RegWrite = 1'b1;
      default: ;
    endcase
  end

  assign illegal = illegal_q;
  assign state   = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class
// through its state sequence and compares state plus the packed control
// word against hand-computed constants.
module tb_multicycle_control;

  logic       clk;
  logic       reset;
  logic [5:0] opcode;
  logic       PCWrite, PCWriteCond, PCWriteCondNE, IorD, MemRead, MemWrite;
  logic       IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, illegal;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic [3:0] state;

  int errors = 0;
  int checks = 0;

  multicycle_control dut (
    .clk(clk), .reset(reset), .opcode(opcode),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCWriteCondNE(PCWriteCondNE),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
    .illegal(illegal), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed control word, grouped as
  // {PCWrite,PCWriteCond,PCWriteCondNE}_{IorD,MemRead,MemWrite,IRWrite}_
  // {MemtoReg,RegDst,RegWrite}_ALUSrcA_ALUSrcB_ALUOp_PCSource_illegal
  logic [17:0] outs;
  assign outs = {PCWrite, PCWriteCond, PCWriteCondNE, IorD, MemRead, MemWrite,
                 IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
                 PCSource, illegal};

  localparam logic [17:0] V_FETCH  = 18'b100_0101_000_0_01_00_00_0;
  localparam logic [17:0] V_FETCHI = 18'b100_0101_000_0_01_00_00_1;
  localparam logic [17:0] V_DECODE = 18'b000_0000_000_0_11_00_00_0;
  localparam logic [17:0] V_MEMADR = 18'b000_0000_000_1_10_00_00_0;
  localparam logic [17:0] V_MEMRD  = 18'b000_1100_000_0_00_00_00_0;
  localparam logic [17:0] V_MEMWB  = 18'b000_0000_101_0_00_00_00_0;
  localparam logic [17:0] V_MEMWR  = 18'b000_1010_000_0_00_00_00_0;
  localparam logic [17:0] V_RTEXEC = 18'b000_0000_000_1_00_10_00_0;
  localparam logic [17:0] V_RTWB   = 18'b000_0000_011_0_00_00_00_0;
  localparam logic [17:0] V_BEQ    = 18'b010_0000_000_1_00_01_01_0;
  localparam logic [17:0] V_BNE    = 18'b001_0000_000_1_00_01_01_0;
  localparam logic [17:0] V_JUMP   = 18'b100_0000_000_0_00_00_10_0;
  localparam logic [17:0] V_ADDIEX = 18'b000_0000_000_1_10_00_00_0;
  localparam logic [17:0] V_ANDIEX = 18'b000_0000_000_1_10_11_00_0;
  localparam logic [17:0] V_ITWB   = 18'b000_0000_001_0_00_00_00_0;
  localparam logic [17:0] V_ZERO   = 18'b0;

  // Compare current state and control word against expectations.
  task automatic chk(input string tag, input logic [3:0] exp_st, input logic [17:0] exp_v);
    checks++;
    assert (state === exp_st) else begin
      errors++;
      $error("FAIL %s state: observed=%0d expected=%0d", tag, state, exp_st);
    end
    checks++;
    assert (outs === exp_v) else begin
      errors++;
      $error("FAIL %s outputs: observed=%b expected=%b", tag, outs, exp_v);
    end
  endtask

  // Generic scalar comparison.
  task automatic chk_val(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Advance one clock; sample 2 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset  = 1'b1;
    opcode = 6'b000000;
    #12;
    chk("reset_fetch", 4'd0, V_FETCH);
    chk_val("reset_opcode_hold", {2'b0, dut.opcode_q}, 8'h00);
    tick();
    chk("reset_held_over_edge", 4'd0, V_FETCH);
    #3 reset = 1'b0;                       // released between edges
    chk("post_release_fetch", 4'd0, V_FETCH);

    // lw: 0,1,2,3,4,0
    opcode = 6'b100011;
    tick(); chk("lw_decode", 4'd1, V_DECODE);
    tick(); chk("lw_memadr", 4'd2, V_MEMADR);
    chk_val("lw_opcode_hold", {2'b0, dut.opcode_q}, 8'h23);
    tick(); chk("lw_memrd", 4'd3, V_MEMRD);
    tick(); chk("lw_memwb", 4'd4, V_MEMWB);
    tick(); chk("lw_fetch", 4'd0, V_FETCH);

    // sw: 0,1,2,5,0; opcode flips to lw during MEMADR and must be ignored
    opcode = 6'b101011;
    tick(); chk("sw_decode", 4'd1, V_DECODE);
    tick(); chk("sw_memadr", 4'd2, V_MEMADR);
    opcode = 6'b100011;
    tick(); chk("sw_memwr", 4'd5, V_MEMWR);
    tick(); chk("sw_fetch", 4'd0, V_FETCH);

    // R-type: 0,1,6,7,0
    opcode = 6'b000000;
    tick(); chk("rt_decode", 4'd1, V_DECODE);
    tick(); chk("rt_exec", 4'd6, V_RTEXEC);
    tick(); chk("rt_wb", 4'd7, V_RTWB);
    tick(); chk("rt_fetch", 4'd0, V_FETCH);

    // addi: 0,1,11,13,0
    opcode = 6'b001000;
    tick(); chk("addi_decode", 4'd1, V_DECODE);
    tick(); chk("addi_exec", 4'd11, V_ADDIEX);
    tick(); chk("addi_wb", 4'd13, V_ITWB);
    tick(); chk("addi_fetch", 4'd0, V_FETCH);

    // andi: 0,1,12,13,0
    opcode = 6'b001100;
    tick(); chk("andi_decode", 4'd1, V_DECODE);
    tick(); chk("andi_exec", 4'd12, V_ANDIEX);
    tick(); chk("andi_wb", 4'd13, V_ITWB);
    tick(); chk("andi_fetch", 4'd0, V_FETCH);

    // beq: 0,1,8,0
    opcode = 6'b000100;
    tick(); chk("beq_decode", 4'd1, V_DECODE);
    tick(); chk("beq_exec", 4'd8, V_BEQ);
    tick(); chk("beq_fetch", 4'd0, V_FETCH);

    // bne: 0,1,10,0
    opcode = 6'b000101;
    tick(); chk("bne_decode", 4'd1, V_DECODE);
    tick(); chk("bne_exec", 4'd10, V_BNE);
    tick(); chk("bne_fetch", 4'd0, V_FETCH);

    // j: 0,1,9,0
    opcode = 6'b000010;
    tick(); chk("j_decode", 4'd1, V_DECODE);
    tick(); chk("j_exec", 4'd9, V_JUMP);
    tick(); chk("j_fetch", 4'd0, V_FETCH);

    // illegal 111111: 0,1,0 with illegal in second FETCH only
    opcode = 6'b111111;
    tick(); chk("ill_decode", 4'd1, V_DECODE);
    tick(); chk("ill_fetch_pulse", 4'd0, V_FETCHI);
    opcode = 6'b000010;
    tick(); chk("ill_pulse_cleared", 4'd1, V_DECODE);
    tick(); chk("ill_next_j", 4'd9, V_JUMP);
    tick(); chk("ill_next_fetch", 4'd0, V_FETCH);

    // Asynchronous reset in MEMRD of a lw, between clock edges
    opcode = 6'b100011;
    tick(); tick(); tick();
    chk("arst_in_memrd", 4'd3, V_MEMRD);
    #1 reset = 1'b1;
    #1;
    chk("arst_immediate", 4'd0, V_FETCH);
    chk_val("arst_opcode_hold", {2'b0, dut.opcode_q}, 8'h00);
    tick();
    chk("arst_held", 4'd0, V_FETCH);
    #3 reset = 1'b0;

    // Full lw after release; opcode changes to sw during MEMADR
    tick(); chk("lw2_decode", 4'd1, V_DECODE);
    tick(); chk("lw2_memadr", 4'd2, V_MEMADR);
    opcode = 6'b101011;
    tick(); chk("lw2_memrd", 4'd3, V_MEMRD);
    tick(); chk("lw2_memwb", 4'd4, V_MEMWB);
    tick(); chk("lw2_fetch", 4'd0, V_FETCH);

    // Unused codes: all outputs 0, next state FETCH
    #1 force dut.state_q = 4'd15;
    #1;
    chk("code15_outputs", 4'd15, V_ZERO);
    chk_val("code15_next", {4'b0, dut.state_d}, 8'h00);
    force dut.state_q = 4'd14;
    #1;
    chk("code14_outputs", 4'd14, V_ZERO);
    chk_val("code14_next", {4'b0, dut.state_d}, 8'h00);
    release dut.state_q;
    reset = 1'b1;
    #1;
    chk("code_recover_reset", 4'd0, V_FETCH);
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
